rob_nport: RTL and testbench

ROB_NPORT -- requirements
Module: rob_nport

---
 rtl/rv32cpu_type.sv | 46 ++++
 rtl/rob_nport.sv | 147 ++++++++++++++
 tb/tb_rob_nport.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32cpu_type.sv
// ---------------------------------------------------------------------------
// rv32cpu_type: shared types and default sizing for the out-of-order core.
//   ROB_DEPTH / CDB_PORTS : default reorder-buffer size and result-bus count
//   rob_entry_t           : one reorder-buffer slot
//   cdb_entry_t           : one common-data-bus broadcast
//   rs_entry_t            : one reservation-station slot
// The rob_id width of the CDB and RS records follows ROB_DEPTH.
// ---------------------------------------------------------------------------
package rv32cpu_type;

    localparam int unsigned ROB_DEPTH = 32;
    localparam int unsigned CDB_PORTS = 2;
    localparam int unsigned ROB_IDW   = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic        valid;
        logic        rd_valid;
        logic [4:0]  rd_s;
        logic        regf_we;
        logic [31:0] pc;
        logic        br;
        logic [1:0]  br_predicted;
        logic        br_actual;
        logic [31:0] rd_v;
    } rob_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ROB_IDW-1:0] rob_id;
        logic [31:0]        rd_v;
        logic               br_actual;
    } cdb_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ROB_IDW-1:0] rob_id;
        logic [6:0]         op;
        logic [31:0]        rs1_v;
        logic [31:0]        rs2_v;
        logic               rs1_rdy;
        logic               rs2_rdy;
        logic [ROB_IDW-1:0] rs1_tag;
        logic [ROB_IDW-1:0] rs2_tag;
    } rs_entry_t;

endpackage

// File: rtl/rob_nport.sv
// ---------------------------------------------------------------------------
// rob_nport: reorder buffer with CDB_PORTS independent result-write ports.
//   clk, rst         : clock, asynchronous active-high reset
//   alloc_*          : in-order dispatch into the tail slot (valid/ready)
//   cdb_*            : per-port result writes by rob_id; lowest port wins
//   commit_*         : in-order retirement from the head slot (valid/ready)
//   flush            : squash, asserted when a mispredicted branch commits
//   full/empty/count : occupancy status
// Head and tail carry an extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module rob_nport #(
    parameter  int unsigned DEPTH     = rv32cpu_type::ROB_DEPTH,
    parameter  int unsigned CDB_PORTS = rv32cpu_type::CDB_PORTS,
    localparam int unsigned IDW       = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    // dispatch
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic [4:0]                     alloc_rd_s,
    input  logic                           alloc_regf_we,
    input  logic [31:0]                    alloc_pc,
    input  logic                           alloc_br,
    input  logic [1:0]                     alloc_br_predicted,
    output logic [IDW-1:0]                 alloc_rob_id,
    // result write
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS-1:0][IDW-1:0]  cdb_rob_id,
    input  logic [CDB_PORTS-1:0][31:0]     cdb_rd_v,
    input  logic [CDB_PORTS-1:0]           cdb_br_actual,
    // commit
    output logic                           commit_valid,
    input  logic                           commit_ready,
    output logic [IDW-1:0]                 commit_rob_id,
    output logic [4:0]                     commit_rd_s,
    output logic [31:0]                    commit_rd_v,
    output logic                           commit_regf_we,
    output logic [31:0]                    commit_pc,
    output logic                           commit_mispredict,
    // status
    output logic                           flush,
    output logic                           full,
    output logic                           empty,
    output logic [IDW:0]                   count
);
    import rv32cpu_type::*;

    rob_entry_t           r_rob [DEPTH];
    logic [IDW:0]         r_head;
    logic [IDW:0]         r_tail;

    logic [IDW-1:0]       w_head_idx;
    logic [IDW-1:0]       w_tail_idx;
    rob_entry_t           w_head_e;
    logic                 w_full;
    logic                 w_mispredict;
    logic                 w_commit_fire;
    logic                 w_alloc_fire;
    logic                 w_flush;
    logic [CDB_PORTS-1:0] w_cdb_win;

    assign w_head_idx = r_head[IDW-1:0];
    assign w_tail_idx = r_tail[IDW-1:0];
    assign w_head_e   = r_rob[w_head_idx];

    assign w_full        = (w_head_idx == w_tail_idx) && (r_head[IDW] != r_tail[IDW]);
    assign w_mispredict  = w_head_e.br && (w_head_e.br_predicted[1] != w_head_e.br_actual);
    assign commit_valid  = w_head_e.valid && w_head_e.rd_valid;
    assign w_commit_fire = commit_valid && commit_ready;
    assign w_flush       = w_commit_fire && w_mispredict;
    assign alloc_ready   = !w_full && !w_flush;
    assign w_alloc_fire  = alloc_valid && alloc_ready;

    assign alloc_rob_id      = w_tail_idx;
    assign commit_rob_id     = w_head_idx;
    assign commit_rd_s       = w_head_e.rd_s;
    assign commit_rd_v       = w_head_e.rd_v;
    assign commit_regf_we    = w_head_e.regf_we;
    assign commit_pc         = w_head_e.pc;
    assign commit_mispredict = w_mispredict;
    assign flush             = w_flush;
    assign full              = w_full;
    assign empty             = (r_head == r_tail);
    assign count             = r_tail - r_head;

    // A port only wins if no lower-indexed valid port targets the same rob_id,
    // so at most one write reaches any entry per cycle.
    for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb_prio
        logic w_shadowed;
        always_comb begin
            w_shadowed = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (cdb_valid[q] && (cdb_rob_id[q] == cdb_rob_id[p])) begin
                    w_shadowed = 1'b1;
                end
            end
        end
        assign w_cdb_win[p] = cdb_valid[p] && !w_shadowed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
        end else if (w_flush) begin
            // Squash everything; CDB writes in this cycle are dropped.
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i].valid    <= 1'b0;
                r_rob[i].rd_valid <= 1'b0;
            end
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (w_cdb_win[p] && r_rob[cdb_rob_id[p]].valid) begin
                    r_rob[cdb_rob_id[p]].rd_valid  <= 1'b1;
                    r_rob[cdb_rob_id[p]].rd_v      <= cdb_rd_v[p];
                    r_rob[cdb_rob_id[p]].br_actual <= cdb_br_actual[p];
                end
            end
            if (w_commit_fire) begin
                r_rob[w_head_idx].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            // Tail slot is invalid here, so no CDB write above can touch it.
            if (w_alloc_fire) begin
                r_rob[w_tail_idx] <= '{
                    valid:        1'b1,
                    rd_valid:     1'b0,
                    rd_s:         alloc_rd_s,
                    regf_we:      alloc_regf_we,
                    pc:           alloc_pc,
                    br:           alloc_br,
                    br_predicted: alloc_br_predicted,
                    br_actual:    1'b0,
                    rd_v:         32'h0
                };
                r_tail <= r_tail + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rob_nport.sv
module tb_rob_nport;
    localparam int DEPTH = 32;
    localparam int NP    = 2;
    localparam int IDW   = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    alloc_valid;
    logic                    alloc_ready;
    logic [4:0]              alloc_rd_s;
    logic                    alloc_regf_we;
    logic [31:0]             alloc_pc;
    logic                    alloc_br;
    logic [1:0]              alloc_br_predicted;
    logic [IDW-1:0]          alloc_rob_id;
    logic [NP-1:0]           cdb_valid;
    logic [NP-1:0][IDW-1:0]  cdb_rob_id;
    logic [NP-1:0][31:0]     cdb_rd_v;
    logic [NP-1:0]           cdb_br_actual;
    logic                    commit_valid;
    logic                    commit_ready;
    logic [IDW-1:0]          commit_rob_id;
    logic [4:0]              commit_rd_s;
    logic [31:0]             commit_rd_v;
    logic                    commit_regf_we;
    logic [31:0]             commit_pc;
    logic                    commit_mispredict;
    logic                    flush;
    logic                    full;
    logic                    empty;
    logic [IDW:0]            count;

    rob_nport #(.DEPTH(DEPTH), .CDB_PORTS(NP)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd_s(alloc_rd_s),
        .alloc_regf_we(alloc_regf_we), .alloc_pc(alloc_pc), .alloc_br(alloc_br),
        .alloc_br_predicted(alloc_br_predicted), .alloc_rob_id(alloc_rob_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_v(cdb_rd_v),
        .cdb_br_actual(cdb_br_actual),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rob_id(commit_rob_id), .commit_rd_s(commit_rd_s), .commit_rd_v(commit_rd_v),
        .commit_regf_we(commit_regf_we), .commit_pc(commit_pc),
        .commit_mispredict(commit_mispredict),
        .flush(flush), .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  id;
        logic [4:0]  rd_s;
        logic        we;
        logic [31:0] pc;
        logic [31:0] rd_v;
        logic        misp;
    } commit_t;

    typedef struct {
        logic [4:0]  rd_s;
        logic        we;
        logic [31:0] pc;
        logic        br;
        logic [1:0]  pred;
        logic [31:0] rd_v;
        logic        bra;
        logic        misp;
    } vec_t;

    commit_t sb[$];
    vec_t    vecs[8];
    int      checks   = 0;
    int      failures = 0;
    int      m_tail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_commit_valid"}, commit_valid, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_alloc_ready"}, alloc_ready, 1);
        chk({tag, "_alloc_rob_id"}, alloc_rob_id, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        m_tail = 0;
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] rd_s, input logic we, input logic [31:0] pc,
                            input logic br, input logic [1:0] pred, input logic [31:0] rd_v,
                            input logic misp);
        commit_t e;
        alloc_valid = 1'b1; alloc_rd_s = rd_s; alloc_regf_we = we; alloc_pc = pc;
        alloc_br = br; alloc_br_predicted = pred;
        #1;
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_rob_id", alloc_rob_id, m_tail % DEPTH);
        e = '{id: 5'(m_tail % DEPTH), rd_s: rd_s, we: we, pc: pc, rd_v: rd_v, misp: misp};
        sb.push_back(e);
        m_tail++;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input int port, input int id, input logic [31:0] v, input logic bra);
        cdb_valid[port] = 1'b1; cdb_rob_id[port] = 5'(id);
        cdb_rd_v[port] = v; cdb_br_actual[port] = bra;
        tick();
        cdb_valid = '0;
    endtask

    // Compares the head commit outputs with the oldest scoreboard entry.
    task automatic check_head(input string tag, output logic misp);
        commit_t e;
        misp = 1'b0;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_sb: got a commit, required none pending", tag);
        end else begin
            e = sb.pop_front();
            misp = e.misp;
            chk({tag, "_valid"}, commit_valid, 1);
            chk({tag, "_rob_id"}, commit_rob_id, e.id);
            chk({tag, "_rd_s"}, commit_rd_s, e.rd_s);
            chk({tag, "_rd_v"}, commit_rd_v, e.rd_v);
            chk({tag, "_regf_we"}, commit_regf_we, e.we);
            chk({tag, "_pc"}, commit_pc, e.pc);
            chk({tag, "_mispredict"}, commit_mispredict, e.misp);
            chk({tag, "_flush"}, flush, e.misp);
        end
    endtask

    task automatic do_commit(input string tag);
        int   n;
        logic misp;
        n = 0;
        commit_ready = 1'b1;
        #1;
        while (commit_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_head(tag, misp);
        tick();
        commit_ready = 1'b0;
        if (misp) begin
            sb.delete();
            m_tail = 0;
        end
    endtask

    initial begin
        logic misp;
        rst = 1'b1; alloc_valid = 0; alloc_rd_s = 0; alloc_regf_we = 0; alloc_pc = 0;
        alloc_br = 0; alloc_br_predicted = 0; cdb_valid = '0; cdb_rob_id = '0;
        cdb_rd_v = '0; cdb_br_actual = '0; commit_ready = 0;

        vecs[0] = '{5'd1,  1'b1, 32'h0000_1000, 1'b0, 2'b11, 32'h1111_0001, 1'b1, 1'b0};
        vecs[1] = '{5'd2,  1'b0, 32'h0000_1004, 1'b1, 2'b10, 32'h2222_0002, 1'b1, 1'b0};
        vecs[2] = '{5'd3,  1'b1, 32'h0000_1008, 1'b1, 2'b10, 32'h3333_0003, 1'b0, 1'b1};
        vecs[3] = '{5'd4,  1'b1, 32'h0000_100C, 1'b1, 2'b01, 32'h4444_0004, 1'b0, 1'b0};
        vecs[4] = '{5'd5,  1'b0, 32'h0000_1010, 1'b1, 2'b00, 32'h5555_0005, 1'b1, 1'b1};
        vecs[5] = '{5'd6,  1'b1, 32'h0000_1014, 1'b1, 2'b11, 32'h6666_0006, 1'b1, 1'b0};
        vecs[6] = '{5'd7,  1'b1, 32'h0000_1018, 1'b0, 2'b00, 32'h7777_0007, 1'b1, 1'b0};
        vecs[7] = '{5'd31, 1'b0, 32'h0000_101C, 1'b1, 2'b01, 32'h8888_0008, 1'b1, 1'b1};

        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;

        // Single-entry flows through the vector table.
        for (int i = 0; i < 8; i++) begin
            do_alloc(vecs[i].rd_s, vecs[i].we, vecs[i].pc, vecs[i].br, vecs[i].pred,
                     vecs[i].rd_v, vecs[i].misp);
            chk("tbl_count", count, 1);
            cdb_valid[i % 2] = 1'b1; cdb_rob_id[i % 2] = 5'((m_tail - 1) % DEPTH);
            cdb_rd_v[i % 2] = vecs[i].rd_v; cdb_br_actual[i % 2] = vecs[i].bra;
            #1;
            chk("tbl_no_bypass", commit_valid, 0);
            tick();
            cdb_valid = '0;
            do_commit("tbl");
            chk("tbl_empty_after", empty, 1);
            if (vecs[i].misp) chk("tbl_flush_rob_id", alloc_rob_id, 0);
        end

        // Fill to full with commit held off.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc(5'(i), 1'b1, 32'h2000 + 32'(i) * 4, 1'b0, 2'b00, 32'hF000_0000 + 32'(i), 1'b0);
        end
        chk("fill_full", full, 1);
        chk("fill_alloc_ready", alloc_ready, 0);
        chk("fill_count", count, 32);
        chk("fill_empty", empty, 0);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("fill_blocked_count", count, 32);
        do_cdb(0, 0, 32'hF000_0000, 1'b0);
        // Alloc and commit together at full: alloc stays blocked.
        alloc_valid = 1'b1; commit_ready = 1'b1;
        #1;
        chk("full_same_cycle_alloc_ready", alloc_ready, 0);
        check_head("full_commit", misp);
        tick();
        alloc_valid = 1'b0; commit_ready = 1'b0;
        chk("full_same_cycle_count", count, 31);
        chk("full_same_cycle_full", full, 0);
        for (int i = 1; i < DEPTH; i += 2) begin
            cdb_valid = 2'b01; cdb_rob_id[0] = 5'(i); cdb_rd_v[0] = 32'hF000_0000 + 32'(i);
            if (i + 1 < DEPTH) begin
                cdb_valid = 2'b11; cdb_rob_id[1] = 5'(i + 1);
                cdb_rd_v[1] = 32'hF000_0000 + 32'(i + 1);
            end
            tick();
            cdb_valid = '0;
        end
        for (int i = 1; i < DEPTH; i++) do_commit("drain");
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Out-of-order completion (pointers now sit on the wrapped zero).
        do_alloc(5'd10, 1'b1, 32'h3000, 1'b0, 2'b00, 32'h3000_0000, 1'b0);
        do_alloc(5'd11, 1'b1, 32'h3004, 1'b0, 2'b00, 32'h3000_0001, 1'b0);
        do_alloc(5'd12, 1'b1, 32'h3008, 1'b0, 2'b00, 32'h3000_0002, 1'b0);
        do_cdb(1, 2, 32'h3000_0002, 1'b0);
        chk("ooo_id2_no_commit", commit_valid, 0);
        cdb_valid[0] = 1'b1; cdb_rob_id[0] = 5'd0; cdb_rd_v[0] = 32'h3000_0000;
        #1;
        chk("ooo_id0_no_bypass", commit_valid, 0);
        tick();
        cdb_valid = '0;
        chk("ooo_id0_latency", commit_valid, 1);
        do_commit("ooo0");
        chk("ooo_id1_blocks", commit_valid, 0);
        chk("ooo_head_id1", commit_rob_id, 1);
        do_cdb(0, 1, 32'h3000_0001, 1'b0);
        do_commit("ooo1");
        do_commit("ooo2");

        // Dual-port conflict on id3: port 0 wins.
        do_alloc(5'd13, 1'b0, 32'h300C, 1'b0, 2'b00, 32'hAAAA_0000, 1'b0);
        cdb_valid = 2'b11;
        cdb_rob_id[0] = 5'd3; cdb_rd_v[0] = 32'hAAAA_0000;
        cdb_rob_id[1] = 5'd3; cdb_rd_v[1] = 32'h5555_FFFF;
        tick();
        cdb_valid = '0;
        do_commit("dual");

        // Mispredict on id1 with younger entries 2..5 in flight.
        do_reset();
        do_alloc(5'd1, 1'b1, 32'h4000, 1'b0, 2'b00, 32'h4000_0000, 1'b0);
        do_alloc(5'd2, 1'b0, 32'h4004, 1'b1, 2'b10, 32'h4000_0001, 1'b1);
        for (int i = 2; i < 6; i++) begin
            do_alloc(5'(i + 1), 1'b1, 32'h4000 + 32'(i) * 4, 1'b0, 2'b00, 32'h4000_0000 + 32'(i),
                     1'b0);
        end
        do_cdb(0, 0, 32'h4000_0000, 1'b0);
        do_cdb(1, 1, 32'h4000_0001, 1'b0);
        do_commit("mp0");
        commit_ready = 1'b1;
        cdb_valid[0] = 1'b1; cdb_rob_id[0] = 5'd2; cdb_rd_v[0] = 32'hDEAD_0002;
        #1;
        chk("mp_alloc_ready", alloc_ready, 0);
        check_head("mp1", misp);
        tick();
        commit_ready = 1'b0; cdb_valid = '0;
        sb.delete();
        m_tail = 0;
        chk("mp_empty", empty, 1);
        chk("mp_count", count, 0);
        chk("mp_alloc_rob_id", alloc_rob_id, 0);
        chk("mp_commit_valid", commit_valid, 0);
        do_cdb(0, 4, 32'hDEAD_0004, 1'b0);
        chk("mp_late_cdb_empty", empty, 1);
        chk("mp_late_cdb_commit_valid", commit_valid, 0);
        for (int i = 0; i < 5; i++) begin
            do_alloc(5'(20 + i), 1'b1, 32'h5000 + 32'(i), 1'b0, 2'b00, 32'h5000_0000 + 32'(i),
                     1'b0);
        end
        for (int i = 0; i < 4; i++) do_cdb(i % 2, i, 32'h5000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) do_commit("mp_after");
        chk("mp_id4_pending", commit_valid, 0);
        do_cdb(1, 4, 32'h5000_0004, 1'b0);
        do_commit("mp_after4");

        // Wrap: 40 alloc/commit pairs at steady count 3.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            do_alloc(5'(n), 1'b1, 32'(n), 1'b0, 2'b00, 32'hC000_0000 | 32'(n), 1'b0);
        end
        do_cdb(0, 0, 32'hC000_0000, 1'b0);
        do_cdb(1, 1, 32'hC000_0001, 1'b0);
        for (int i = 0; i < 40; i++) begin
            commit_t e;
            alloc_valid = 1'b1; alloc_rd_s = 5'(i + 3); alloc_regf_we = 1'b1;
            alloc_pc = 32'(i + 3); alloc_br = 1'b0; alloc_br_predicted = 2'b00;
            commit_ready = 1'b1;
            cdb_valid = 2'b01; cdb_rob_id[0] = 5'((i + 2) % DEPTH);
            cdb_rd_v[0] = 32'hC000_0000 | 32'(i + 2); cdb_br_actual[0] = 1'b0;
            #1;
            chk("wrap_commit_rob_id", commit_rob_id, i % DEPTH);
            check_head("wrap", misp);
            chk("wrap_alloc_ready", alloc_ready, 1);
            chk("wrap_alloc_rob_id", alloc_rob_id, (i + 3) % DEPTH);
            chk("wrap_count", count, 3);
            e = '{id: 5'((i + 3) % DEPTH), rd_s: 5'(i + 3), we: 1'b1, pc: 32'(i + 3),
                  rd_v: 32'hC000_0000 | 32'(i + 3), misp: 1'b0};
            sb.push_back(e);
            tick();
        end
        alloc_valid = 1'b0; commit_ready = 1'b0; cdb_valid = '0;
        chk("wrap_final_count", count, 3);

        // Reset between clock edges with ten entries in flight.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_alloc(5'(i), 1'b1, 32'h6000 + 32'(i), 1'b0, 2'b00, 32'h0, 1'b0);
        end
        chk("midrst_pre_count", count, 10);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        m_tail = 0;
        #1;
        do_alloc(5'd9, 1'b1, 32'h7000, 1'b0, 2'b00, 32'h7000_0000, 1'b0);
        chk("midrst_post_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion within 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
